// File: rtl/fb_fill_master_if.sv
// Wishbone write-only link between the fill master and the framebuffer slave.
//   O_wb_adr  byte address (pixel_index << 2)
//   O_wb_dat  write data (RGB332)
//   O_wb_we   write enable
//   O_wb_stb  strobe
//   O_wb_cyc  cycle
//   I_wb_ack  slave acknowledge
interface fb_fill_master_if #(
  parameter int unsigned ADR_W = 17
);
  logic [ADR_W-1:0] O_wb_adr;
  logic [7:0]       O_wb_dat;
  logic             O_wb_we;
  logic             O_wb_stb;
  logic             O_wb_cyc;
  logic             I_wb_ack;

  modport master (
    output O_wb_adr, O_wb_dat, O_wb_we, O_wb_stb, O_wb_cyc,
    input  I_wb_ack
  );

  modport slave (
    input  O_wb_adr, O_wb_dat, O_wb_we, O_wb_stb, O_wb_cyc,
    output I_wb_ack
  );
endinterface

// File: rtl/fb_fill_master.sv
// Wishbone master filling a clipped rectangle of the framebuffer with one colour,
// one single-beat write per pixel.
//   I_wb_clk, I_wb_rst       clock, asynchronous active-high reset
//   I_start                  command strobe (accepted only in IDLE)
//   I_x0/I_y0/I_w/I_h        rectangle origin and size
//   I_color                  fill value
//   O_busy/O_done/O_err      status: in progress, completion pulse, sticky timeout
//   O_pix_count              acked writes in current/last command
//   wb                       Wishbone master port
module fb_fill_master #(
  parameter int unsigned FB_WIDTH  = 160,
  parameter int unsigned FB_HEIGHT = 120,
  parameter int unsigned ADR_W     = 17,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        I_wb_clk,
  input  logic        I_wb_rst,
  input  logic        I_start,
  input  logic [7:0]  I_x0,
  input  logic [6:0]  I_y0,
  input  logic [7:0]  I_w,
  input  logic [6:0]  I_h,
  input  logic [7:0]  I_color,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic [14:0] O_pix_count,
  fb_fill_master_if.master wb
);

  localparam int unsigned PIX_W  = 15;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_NEXT, S_DONE} state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_x0, w_x0_nxt;
  logic [6:0]         r_y0, w_y0_nxt;
  logic [7:0]         r_w, w_w_nxt;
  logic [6:0]         r_h, w_h_nxt;
  logic [7:0]         r_color, w_color_nxt;
  logic [8:0]         r_x_end, w_x_end_nxt;
  logic [7:0]         r_y_end, w_y_end_nxt;
  logic [7:0]         r_x, w_x_nxt;
  logic [6:0]         r_y, w_y_nxt;
  logic [PIX_W-1:0]   r_row_base, w_row_base_nxt;
  logic [TCNT_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic [ADR_W-1:0]   r_adr, w_adr_nxt;
  logic               r_stb, w_stb_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_err, w_err_nxt;
  logic [PIX_W-1:0]   r_pix_count, w_pix_count_nxt;

  // Clipping: sums are one bit wider than the operands so they cannot wrap
  logic [8:0] w_x_sum;
  logic [7:0] w_y_sum;
  logic       w_empty;
  logic       w_x_last;
  logic       w_y_last;

  assign w_x_sum  = 9'(r_x0) + 9'(r_w);
  assign w_y_sum  = 8'(r_y0) + 8'(r_h);
  assign w_empty  = (9'(r_x0) >= 9'(FB_WIDTH)) || (8'(r_y0) >= 8'(FB_HEIGHT)) ||
                    (r_w == 8'd0) || (r_h == 7'd0);
  assign w_x_last = (9'(r_x) + 9'd1) == r_x_end;
  assign w_y_last = (8'(r_y) + 8'd1) == r_y_end;

  // State and datapath registers
  always_ff @(posedge I_wb_clk or posedge I_wb_rst) begin
    if (I_wb_rst) begin
      r_state     <= S_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_x_end     <= '0;
      r_y_end     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_row_base  <= '0;
      r_tcnt      <= '0;
      r_adr       <= '0;
      r_stb       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pix_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_x0        <= w_x0_nxt;
      r_y0        <= w_y0_nxt;
      r_w         <= w_w_nxt;
      r_h         <= w_h_nxt;
      r_color     <= w_color_nxt;
      r_x_end     <= w_x_end_nxt;
      r_y_end     <= w_y_end_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_row_base  <= w_row_base_nxt;
      r_tcnt      <= w_tcnt_nxt;
      r_adr       <= w_adr_nxt;
      r_stb       <= w_stb_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_pix_count <= w_pix_count_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_x0_nxt        = r_x0;
    w_y0_nxt        = r_y0;
    w_w_nxt         = r_w;
    w_h_nxt         = r_h;
    w_color_nxt     = r_color;
    w_x_end_nxt     = r_x_end;
    w_y_end_nxt     = r_y_end;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_row_base_nxt  = r_row_base;
    w_tcnt_nxt      = r_tcnt;
    w_adr_nxt       = r_adr;
    w_stb_nxt       = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = r_err;
    w_pix_count_nxt = r_pix_count;

    case (r_state)
      S_IDLE: begin
        if (I_start) begin
          w_x0_nxt        = I_x0;
          w_y0_nxt        = I_y0;
          w_w_nxt         = I_w;
          w_h_nxt         = I_h;
          w_color_nxt     = I_color;
          w_err_nxt       = 1'b0;
          w_pix_count_nxt = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_SETUP;
        end
      end
      S_SETUP: begin
        w_x_end_nxt = (w_x_sum > 9'(FB_WIDTH))  ? 9'(FB_WIDTH)  : w_x_sum;
        w_y_end_nxt = (w_y_sum > 8'(FB_HEIGHT)) ? 8'(FB_HEIGHT) : w_y_sum;
        if (w_empty) begin
          w_state_nxt = S_DONE;
        end else begin
          w_x_nxt        = r_x0;
          w_y_nxt        = r_y0;
          // Constant multiply; reduces to shift-add in synthesis
          w_row_base_nxt = PIX_W'(r_y0) * PIX_W'(FB_WIDTH);
          w_busy_nxt     = 1'b1;
          w_stb_nxt      = 1'b1;
          w_tcnt_nxt     = '0;
          w_state_nxt    = S_WRITE;
        end
      end
      S_WRITE: begin
        w_busy_nxt = 1'b1;
        if (wb.I_wb_ack) begin
          w_pix_count_nxt = r_pix_count + PIX_W'(1);
          if (w_x_last && w_y_last) begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_NEXT;
          end
        end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_tcnt_nxt = r_tcnt + TCNT_W'(1);
          w_stb_nxt  = 1'b1;
        end
      end
      S_NEXT: begin
        // Strobe-low gap absorbs the duplicate ack of the registered slave
        if (w_x_last) begin
          w_x_nxt        = r_x0;
          w_y_nxt        = r_y + 7'd1;
          w_row_base_nxt = r_row_base + PIX_W'(FB_WIDTH);
        end else begin
          w_x_nxt = r_x + 8'd1;
        end
        w_busy_nxt  = 1'b1;
        w_stb_nxt   = 1'b1;
        w_tcnt_nxt  = '0;
        w_state_nxt = S_WRITE;
      end
      S_DONE: begin
        // Empty commands arrive without the pulse and spend one extra cycle here
        if (r_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Address is loaded once per beat and held while the strobe is high
    if ((w_state_nxt == S_WRITE) && (r_state != S_WRITE)) begin
      w_adr_nxt = ADR_W'({w_row_base_nxt + PIX_W'(w_x_nxt), 2'b00});
    end
  end

  assign O_busy       = r_busy;
  assign O_done       = r_done;
  assign O_err        = r_err;
  assign O_pix_count  = r_pix_count;
  assign wb.O_wb_adr  = r_adr;
  assign wb.O_wb_dat  = r_color;
  assign wb.O_wb_we   = r_stb;
  assign wb.O_wb_stb  = r_stb;
  assign wb.O_wb_cyc  = r_stb;

endmodule

// File: doc/fb_fill_master.md
# fb_fill_master

Wishbone master that fills a clipped rectangle of the 160x120 RGB332 framebuffer with a single colour. It issues one single-beat write per pixel, using word-aligned addressing (pixel index × 4). It sits between a command source (ESP32 register bank or sprite engine) and the framebuffer's Wishbone slave port, in the I_wb_clk domain. It is the initiator counterpart of the framebuffer slave: it provides hardware clear-screen and box fills without per-pixel SPI traffic.

## Interface
Parameters:
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels
- ADR_W, 17, Wishbone address width (holds 19199×4)
- TIMEOUT, 255, maximum cycles to wait for ack per beat

Ports:
- I_wb_clk  in  1  Wishbone clock; all logic on rising edge
- I_wb_rst  in  1  reset, asynchronous, active-high
- I_start  in  1  command strobe; sampled only in IDLE
- I_x0  in  8  rectangle left column
- I_y0  in  7  rectangle top row
- I_w  in  8  width in pixels
- I_h  in  7  height in pixels
- I_color  in  8  RGB332 fill value
- O_busy  out  1  command in progress
- O_done  out  1  one-cycle completion pulse
- O_err  out  1  sticky timeout flag
- O_pix_count  out  15  acked writes in current/last command
- O_wb_adr  out  ADR_W  byte address = pixel_index << 2
- O_wb_dat  out  8  write data (= latched colour)
- O_wb_we  out  1  always 1 while O_wb_stb is high
- O_wb_stb  out  1  strobe
- O_wb_cyc  out  1  cycle; identical to O_wb_stb
- I_wb_ack  in  1  slave acknowledge

## Operation
- Reset: all outputs 0; FSM in IDLE. Reset mid-command aborts immediately with no further bus activity.
- FSM states: IDLE, SETUP, WRITE, NEXT, DONE.
- IDLE, I_start=1: latch all command inputs; clear O_err and O_pix_count; go to SETUP.
- SETUP (1 cycle): clip the rectangle.
  - x_end = min(x0+w, FB_WIDTH); y_end = min(y0+h, FB_HEIGHT). Compute with 9-bit and 8-bit sums so there is no wrap.
  - If x0≥FB_WIDTH, y0≥FB_HEIGHT, w=0 or h=0: zero writes, go to DONE.
  - Otherwise set x=x0, y=y0, row_base=y0*160 (shift-add: y<<7 + y<<5), and go to WRITE.
- WRITE: stb=cyc=we=1; adr=(row_base+x)<<2; dat=colour.
  - On ack: O_pix_count+1. If this was the last pixel (x=x_end-1 and y=y_end-1), go to DONE. Otherwise go to NEXT.
- NEXT (1 cycle, stb=0): advance x. If x=x_end-1, set x=x0, y+1, and row_base+=FB_WIDTH. Go to WRITE.
- The NEXT gap is mandatory: the slave acks with a registered one-cycle delay, so a strobe held through the ack cycle produces a second (duplicate) ack. I_wb_ack is ignored in every state except WRITE.
- Timeout: a cycle counter clears on entry to WRITE. If it reaches TIMEOUT without ack, drop stb/cyc, set O_err=1 and go to DONE.
- DONE (1 cycle): O_done=1, then go to IDLE.
- O_busy=1 in SETUP, WRITE and NEXT.
- I_start outside IDLE is ignored (no queueing).
- Outputs are registered. Address and data are stable for the whole time stb is high.

## Timing
- I_start sampled at edge s. SETUP follows, and O_wb_stb is first high after edge s+1.
- Against the 1-cycle registered-ack slave, each pixel costs 3 cycles (2 in WRITE, 1 in NEXT); the last pixel has no NEXT.
- For N≥1 pixels, O_done is high in the cycle after edge s+3N. For N=0, O_done is high after edge s+2.
- Full screen (19200 px): 57,600 cycles from start to done.
- O_err and O_pix_count hold their values after DONE until the next accepted start.
- Back-to-back commands: I_start high in the cycle O_done is high is ignored. It is accepted in the following IDLE cycle.

## Test plan
- Fill x0=0,y0=0,w=2,h=2,colour=0xE0 with the reference slave -> writes to adr 0,4,640,644; O_pix_count=4; O_done after s+12; framebuffer[0,1,160,161]=0xE0.
- Full clear w=160,h=120,colour=0x00 -> 19200 acked writes; last adr=76796; O_done at s+57600; no address ≥76800.
- Clipping x0=150,y0=115,w=20,h=20 -> 10×5=50 writes; first adr=(115*160+150)*4=74200; last adr=76796.
- Empty commands w=0; x0=200; y0=120 -> no stb ever; O_done at s+2; O_pix_count=0.
- Slave never acks, TIMEOUT=255 -> stb high for exactly 255 cycles, then stb/cyc=0; O_err=1, O_done pulses; the next start clears O_err.
- I_start re-asserted while busy, and I_wb_rst asserted mid-fill -> the repeated start is ignored; reset drives all outputs to 0 within the same cycle and O_pix_count=0.
